// File: rtl/mul_pkg.sv
// Shared constants and types for the sequential shift-add multiplier.
package mul_pkg;

  localparam int unsigned MUL_N      = 32;
  localparam int unsigned MUL_CNT_W  = $clog2(MUL_N);
  localparam int unsigned MUL_CNT_LAST = MUL_N - 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: conditional add of mcand into hi, then a
// (2N+1)-bit right shift of {carry,hi,lo}.
module mul_step #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0]   hi,
  input  logic [N-1:0]   lo,
  input  logic [N-1:0]   mcand,
  output logic [2*N-1:0] prod_next
);

  logic [N:0] sum;

  always_comb begin
    sum = {1'b0, hi};
    if (lo[0]) begin
      sum = {1'b0, hi} + {1'b0, mcand};
    end
    prod_next = {sum, lo[N-1:1]};
  end

endmodule

// File: rtl/multu_seq.sv
// Sequential N-cycle shift-add multiplier with start/busy/done handshake.
// Optional signed mode enabled by defining MULT_SIGNED_EN.
module multu_seq
  import mul_pkg::*;
#(
  parameter int unsigned N = MUL_N
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef MULT_SIGNED_EN
  input  logic         is_signed,
`endif
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  mul_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N-1:0]   mcand, mcand_n;
  logic [N-1:0]   hi_n, lo_n;
  logic           done_n;
  logic [N-1:0]   a_op, b_op;
  logic           neg, neg_n;
  logic           neg_acc;
  logic [2*N-1:0] prod_step;
  logic [2*N-1:0] prod_final;

  // Operand conditioning at accept: magnitudes and result sign in signed mode.
`ifdef MULT_SIGNED_EN
  always_comb begin
    a_op    = a;
    b_op    = b;
    neg_acc = 1'b0;
    if (is_signed) begin
      a_op    = a[N-1] ? N'(-a) : a;
      b_op    = b[N-1] ? N'(-b) : b;
      neg_acc = a[N-1] ^ b[N-1];
    end
  end
  assign prod_final = neg ? (2*N)'(-prod_step) : prod_step;
`else
  assign a_op       = a;
  assign b_op       = b;
  assign neg_acc    = 1'b0;
  assign prod_final = prod_step;
`endif

  mul_step #(.N(N)) u_step (
    .hi       (hi),
    .lo       (lo),
    .mcand    (mcand),
    .prod_next(prod_step)
  );

  // Next-state and datapath update.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mcand_n = mcand;
    hi_n    = hi;
    lo_n    = lo;
    neg_n   = neg;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_BUSY;
          mcand_n = a_op;
          hi_n    = '0;
          lo_n    = b_op;
          cnt_n   = '0;
          neg_n   = neg_acc;
        end
      end
      ST_BUSY: begin
        {hi_n, lo_n} = prod_step;
        cnt_n        = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          {hi_n, lo_n} = prod_final;
          state_n      = ST_IDLE;
          done_n       = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      neg   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      mcand <= mcand_n;
      hi    <= hi_n;
      lo    <= lo_n;
      neg   <= neg_n;
      done  <= done_n;
    end
  end

  assign busy = (state == ST_BUSY);

endmodule

// File: doc/multu_seq.md
Name: multu_seq

Overview:
- Sequential shift-add unsigned multiplier; the inverse-operation companion to the team's iterative divider.
- Serves MULTU (and MULT, when the optional feature is enabled) in the 54-instruction CPU.
- Produces a 2N-bit product as hi/lo after N iteration cycles.
- Uses the same start/busy handshake as the divider, so the CPU stall logic treats both blocks identically.

Parameters:
- N, 32, operand width; product is 2N bits.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset (sampled on posedge clock only).
- start  input  1  request; accepted only when busy==0.
- a  input  N  multiplicand.
- b  input  N  multiplier.
- hi  output  N  upper half of product.
- lo  output  N  lower half of product.
- busy  output  1  high while iterating; CPU stalls on it.
- done  output  1  one-cycle pulse; hi/lo valid from this cycle.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - busy=0, done=0, count=0, hi=0, lo=0, internal carry=0.
  - Applies identically mid-operation; the operation is abandoned and no done pulse is issued.
- Accept:
  - Edge where start=1 and busy=0: latch mcand<=a, hi<=0, lo<=b, count<=0, busy<=1, done<=0.
  - start while busy=1 is ignored, with no effect on state.
- Iterate (busy=1), one step per edge:
  - sum[N:0] = lo[0] ? ({1'b0,hi} + {1'b0,mcand}) : {1'b0,hi}.
  - {hi,lo} <= {sum, lo[N-1:1]}, i.e. a (2N+1)-bit right shift of {sum,lo}.
  - count <= count+1.
- Complete: on the edge where count==N-1 the final iteration executes; busy<=0, done<=1.
- Latency:
  - Accept edge E0; busy high after E0.
  - busy falls and done rises after edge E0+N (N=32 → 32 busy cycles).
  - done drops after the next edge.
- Outputs:
  - hi/lo are direct register outputs and hold their value until the next accepted start or reset.
  - During busy they show intermediate values and must not be consumed.
- Back-to-back: start in the done cycle (busy=0) is accepted; done falls and busy rises on that edge.
- Width rules: the carry into bit N of sum is never lost. Worst case (2^N-1)^2 fits exactly in 2N bits.
- Operand capture: operand inputs are sampled only at the accept edge; later changes have no effect.

Optional Feature:
- Macro MULT_SIGNED_EN.
- Defined:
  - Extra input port is_signed (1 bit), sampled at accept.
  - If is_signed=1, the magnitudes of a and b are latched and neg<=a[N-1]^b[N-1].
  - Outputs {hi,lo} = neg ? -(product register) : product register, as 2N-bit two's complement; same N-cycle latency.
  - Handles a=b=-2^(N-1): product 2^(2N-2), positive, correct.
  - neg is cleared by reset and by any unsigned accept.
- Undefined: no is_signed port; unsigned only; no negation logic synthesised.

Decomposition:
- Package mul_pkg:
  - MUL_N=32.
  - MUL_CNT_W=$clog2(MUL_N).
  - localparam for the final count value (MUL_N-1).
- Optional sub-module mul_step: combinational conditional add plus right shift of {hi,lo}, returning the next {hi,lo}.
- The control FSM (IDLE/BUSY, encoded by busy) and counter stay in multu_seq.

Test Plan:
- Basic: a=3, b=5, start 1 cycle → busy high exactly 32 cycles, done pulse 1 cycle, hi=0x00000000, lo=0x0000000F.
- Maximum: a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Zero and operand change:
  - a=0x12345678, b=0 → hi=lo=0.
  - Change a,b during busy → result unchanged.
- Start during busy, then back-to-back:
  - a=7, b=9; pulse start again at cycle 10 with a=2, b=2 → ignored, result lo=63.
  - Then start in the done cycle with a=2, b=2 → accepted, lo=4 after 32 more cycles.
- Reset mid-operation: assert reset at cycle 15 → next edge busy=0, done=0, hi=lo=0; no done pulse follows; a new start then completes normally.
- (MULT_SIGNED_EN) Signed cases:
  - is_signed=1, a=0xFFFFFFFE (-2), b=3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Same operands with is_signed=0 → hi=0x00000002, lo=0xFFFFFFFA.
